// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: request kinds,
// CSR addresses, mstatus bit positions and controller states.
package trap_ctrl_pkg;

   typedef enum logic [1:0] {
      TRAP_KIND_ECALL  = 2'b00,
      TRAP_KIND_EBREAK = 2'b01,
      TRAP_KIND_MRET   = 2'b10,
      TRAP_KIND_RSVD   = 2'b11
   } trap_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAVE,
      ST_REDIR,
      ST_HALT
   } trap_state_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int unsigned MCAUSE_ECALL_M = 11;
   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;

   function automatic logic csr_implemented(input logic [11:0] addr);
      return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
             (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
   endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Request and CSR access bus between decode/exec (master) and the trap
// controller (slave).
interface trap_ctrl_if #(
   parameter int unsigned XLEN = 64
) ();

   logic            trap_req;
   logic            trap_ready;
   logic [1:0]      trap_kind;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] trap_a0;

   logic            csr_we;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_illegal;

   modport master (
      output trap_req, trap_kind, trap_pc, trap_a0,
      output csr_we, csr_addr, csr_wdata,
      input  trap_ready, csr_rdata, csr_illegal
   );

   modport slave (
      input  trap_req, trap_kind, trap_pc, trap_a0,
      input  csr_we, csr_addr, csr_wdata,
      output trap_ready, csr_rdata, csr_illegal
   );

endinterface

// File: rtl/trap_ctrl_csr_file.sv
// Machine-mode trap CSRs (mstatus/mtvec/mepc/mcause): storage, write masking,
// trap-entry/return updates and the combinational read mux.
module trap_csr_file
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_MTVEC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [11:0]     wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [11:0]     rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            illegal,
   input  logic            save_ecall,
   input  logic            save_mret,
   input  logic [XLEN-1:0] save_pc,
   output logic [XLEN-1:0] mtvec_q,
   output logic [XLEN-1:0] mepc_q
);

   logic            mie_q;
   logic            mpie_q;
   logic [XLEN-1:0] mcause_q;

   // Writes only occur in IDLE and save strobes only in SAVE, so they never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mtvec_q  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
         mepc_q   <= '0;
         mcause_q <= '0;
      end else begin
         if (wr_en) begin
            case (wr_addr)
               CSR_MSTATUS: begin
                  mie_q  <= wr_data[MSTATUS_MIE];
                  mpie_q <= wr_data[MSTATUS_MPIE];
               end
               CSR_MTVEC:  mtvec_q  <= {wr_data[XLEN-1:2], 2'b00};
               CSR_MEPC:   mepc_q   <= {wr_data[XLEN-1:2], 2'b00};
               CSR_MCAUSE: mcause_q <= wr_data;
               default: ;
            endcase
         end
         if (save_ecall) begin
            mepc_q   <= {save_pc[XLEN-1:2], 2'b00};
            mcause_q <= XLEN'(MCAUSE_ECALL_M);
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end
         if (save_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      illegal = !csr_implemented(rd_addr);
      case (rd_addr)
         CSR_MSTATUS: begin
            rd_data[MSTATUS_MIE]  = mie_q;
            rd_data[MSTATUS_MPIE] = mpie_q;
            rd_data[12:11]        = 2'b11;
         end
         CSR_MTVEC:  rd_data = mtvec_q;
         CSR_MEPC:   rd_data = mepc_q;
         CSR_MCAUSE: rd_data = mcause_q;
         default:    rd_data = '0;
      endcase
   end

endmodule

// File: rtl/trap_ctrl.sv
// Environment-call responder: accepts ECALL/EBREAK/MRET, sequences the trap
// CSR update, issues a one-cycle fetch redirect and holds a sticky halt.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_MTVEC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   trap_ctrl_if.slave      bus,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            halt_valid,
   output logic [XLEN-1:0] halt_pc,
   output logic [XLEN-1:0] halt_code
);

   trap_state_e     state_q, state_d;
   trap_kind_e      req_kind;
   logic            is_mret_q;
   logic [XLEN-1:0] pc_q;
   logic            accept;
   logic            save_ecall;
   logic            save_mret;
   logic            csr_wr_en;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mepc_q;

   assign req_kind       = trap_kind_e'(bus.trap_kind);
   assign bus.trap_ready = (state_q == ST_IDLE);
   assign csr_wr_en      = bus.csr_we && (state_q == ST_IDLE);

   always_comb begin
      state_d        = state_q;
      accept         = 1'b0;
      save_ecall     = 1'b0;
      save_mret      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.trap_req) begin
               accept = 1'b1;
               case (req_kind)
                  TRAP_KIND_ECALL,
                  TRAP_KIND_MRET:   state_d = ST_SAVE;
                  TRAP_KIND_EBREAK: state_d = ST_HALT;
                  default:          state_d = ST_IDLE;
               endcase
            end
         end
         ST_SAVE: begin
            save_ecall = !is_mret_q;
            save_mret  = is_mret_q;
            state_d    = ST_REDIR;
         end
         ST_REDIR: begin
            // Target is read after SAVE has committed, so MRET sees the current mepc.
            redirect_valid = 1'b1;
            redirect_pc    = is_mret_q ? mepc_q : mtvec_q;
            state_d        = ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         is_mret_q  <= 1'b0;
         pc_q       <= '0;
         halt_valid <= 1'b0;
         halt_pc    <= '0;
         halt_code  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            if (req_kind == TRAP_KIND_EBREAK) begin
               halt_valid <= 1'b1;
               halt_pc    <= bus.trap_pc;
               halt_code  <= bus.trap_a0;
            end else begin
               is_mret_q <= (req_kind == TRAP_KIND_MRET);
               pc_q      <= {bus.trap_pc[XLEN-1:2], 2'b00};
            end
         end
      end
   end

   trap_csr_file #(
      .XLEN        (XLEN),
      .RESET_MTVEC (RESET_MTVEC)
   ) u_csr (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (csr_wr_en),
      .wr_addr    (bus.csr_addr),
      .wr_data    (bus.csr_wdata),
      .rd_addr    (bus.csr_addr),
      .rd_data    (bus.csr_rdata),
      .illegal    (bus.csr_illegal),
      .save_ecall (save_ecall),
      .save_mret  (save_mret),
      .save_pc    (pc_q),
      .mtvec_q    (mtvec_q),
      .mepc_q     (mepc_q)
   );

endmodule
